intr_vector_ctrl: RTL and testbench

//  Vectored interrupt controller directly upstream of the MC1201.02 CPU module. Collects level

---
 rtl/intr_vector_ctrl.sv | 174 +++++++++++++++++
 tb/tb_intr_vector_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/intr_vector_ctrl.sv
// intr_vector_ctrl: vectored interrupt controller in front of the MC1201.02 CPU.
// Collects level requests, arbitrates, raises virq and answers the istb -> ivec/iack
// vector fetch. On completion it pulses irq_ack_o for the serviced channel.
// Optional feature: define INTR_RR_EN for rotating priority (default: fixed, ch0 highest).
module intr_vector_ctrl #(
  parameter int          NREQ      = 8,
  parameter logic [15:0] STRAY_VEC = 16'o0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n,
  input  logic [NREQ-1:0]      irq_i,
  input  logic [16*NREQ-1:0]   vec_i,
  output logic [NREQ-1:0]      irq_ack_o,
  output logic                 virq_o,
  input  logic                 istb_i,
  output logic [15:0]          ivec_o,
  output logic                 iack_o
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              virq_q, virq_d;
  logic              iack_q, iack_d;
  logic [15:0]       ivec_q, ivec_d;
  logic [NREQ-1:0]   irq_ack_q, irq_ack_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              stray_q, stray_d;
`ifdef INTR_RR_EN
  logic [IDXW-1:0]   ptr_q, ptr_d;
`endif

  logic [15:0]       vec_arr [NREQ];
  logic [IDXW-1:0]   win_idx;
  logic              any_req;

  // Unpack the flat vector bus into one 16-bit word per channel
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_vec
      assign vec_arr[gi] = vec_i[16*gi +: 16];
    end
  endgenerate

  // Arbitration: pick the first requesting channel, scanning from the search start
  always_comb begin
    int ch;
    ch      = 0;
    win_idx = '0;
    any_req = |irq_i;
`ifdef INTR_RR_EN
    // Scan downwards so the channel nearest the pointer is assigned last and wins
    for (int i = NREQ - 1; i >= 0; i--) begin
      ch = (int'(ptr_q) + i) % NREQ;
      if (irq_i[ch]) win_idx = IDXW'(ch);
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      ch = i;
      if (irq_i[ch]) win_idx = IDXW'(ch);
    end
`endif
  end

  // Next-state and registered-output logic for the handshake FSM
  always_comb begin
    state_d   = state_q;
    virq_d    = virq_q;
    iack_d    = iack_q;
    ivec_d    = ivec_q;
    irq_ack_d = '0;
    idx_d     = idx_q;
    stray_d   = stray_q;
`ifdef INTR_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        // istb here is ignored; the CPU waits for virq
        virq_d = 1'b0;
        iack_d = 1'b0;
        ivec_d = '0;
        if (any_req) begin
          state_d = PEND;
          virq_d  = 1'b1;
        end
      end
      PEND: begin
        virq_d = 1'b1;
        // A higher-priority request may still take over until istb is seen
        idx_d  = win_idx;
        if (istb_i) begin
          state_d = ACK;
          iack_d  = 1'b1;
          stray_d = ~any_req;
          ivec_d  = any_req ? vec_arr[win_idx] : STRAY_VEC;
        end else if (!any_req) begin
          state_d = IDLE;
          virq_d  = 1'b0;
        end
      end
      ACK: begin
        // Request withdrawal is ignored once the vector has been committed
        if (istb_i) begin
          virq_d = 1'b1;
          iack_d = 1'b1;
        end else begin
          state_d = DONE;
          virq_d  = 1'b0;
          iack_d  = 1'b0;
          ivec_d  = '0;
          if (!stray_q) begin
            irq_ack_d[idx_q] = 1'b1;
`ifdef INTR_RR_EN
            ptr_d = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
`endif
          end
        end
      end
      DONE: begin
        // Dead cycle so the device can drop its request before re-arbitration
        state_d = IDLE;
        virq_d  = 1'b0;
        iack_d  = 1'b0;
        ivec_d  = '0;
      end
      default: begin
        state_d = IDLE;
        virq_d  = 1'b0;
        iack_d  = 1'b0;
        ivec_d  = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any handshake without an acknowledge
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      virq_q    <= 1'b0;
      iack_q    <= 1'b0;
      ivec_q    <= '0;
      irq_ack_q <= '0;
      idx_q     <= '0;
      stray_q   <= 1'b0;
`ifdef INTR_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      virq_q    <= virq_d;
      iack_q    <= iack_d;
      ivec_q    <= ivec_d;
      irq_ack_q <= irq_ack_d;
      idx_q     <= idx_d;
      stray_q   <= stray_d;
`ifdef INTR_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign virq_o    = virq_q;
  assign iack_o    = iack_q;
  assign ivec_o    = ivec_q;
  assign irq_ack_o = irq_ack_q;

endmodule

// File: tb/tb_intr_vector_ctrl.sv
// Directed bench for intr_vector_ctrl with a scoreboard of expected vectors/acks.
module tb_intr_vector_ctrl;
  localparam int NREQ = 8;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      irq_i;
  logic [16*NREQ-1:0]   vec_i;
  logic [NREQ-1:0]      irq_ack_o;
  logic                 virq_o;
  logic                 istb_i;
  logic [15:0]          ivec_o;
  logic                 iack_o;

  int checks = 0;
  int errors = 0;

  logic [15:0]     exp_vec_q [$];
  logic [NREQ-1:0] exp_ack_q [$];

  logic            ack_window = 1'b0;
  logic            rearm_en   = 1'b0;
  logic [NREQ-1:0] rearm_pend = '0;

  intr_vector_ctrl #(.NREQ(NREQ), .STRAY_VEC(16'o0)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .irq_i     (irq_i),
    .vec_i     (vec_i),
    .irq_ack_o (irq_ack_o),
    .virq_o    (virq_o),
    .istb_i    (istb_i),
    .ivec_o    (ivec_o),
    .iack_o    (iack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1ns after the edge, run the device model, check invariants
  task automatic tick();
    @(posedge clk);
    #1;
    irq_i      = irq_i | rearm_pend;
    rearm_pend = '0;
    chk("iack_with_irq_ack", {31'd0, (iack_o & (|irq_ack_o))}, 32'd0);
    if (!ack_window) chk("unexpected_irq_ack", {24'd0, irq_ack_o}, 32'd0);
    if (|irq_ack_o) begin
      irq_i = irq_i & ~irq_ack_o;
      if (rearm_en) rearm_pend = irq_ack_o;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    istb_i = 1'b0;
    irq_i = '0;
    rearm_en = 1'b0;
    rearm_pend = '0;
    tick();
    tick();
    chk("rst_virq", {31'd0, virq_o}, 32'd0);
    chk("rst_iack", {31'd0, iack_o}, 32'd0);
    chk("rst_ivec", {16'd0, ivec_o}, 32'd0);
    rst_n = 1'b1;
  endtask

  // CPU side of one vector fetch; expectations are queued first, popped at compare
  task automatic service(input logic [15:0] ev, input logic [NREQ-1:0] ea,
                         input int wait_pre, input int hold, input logic [NREQ-1:0] clr_at_istb);
    int n;
    exp_vec_q.push_back(ev);
    exp_ack_q.push_back(ea);
    n = 0;
    while (!virq_o && n < 50) begin
      tick();
      n++;
    end
    chk("virq_seen", {31'd0, virq_o}, 32'd1);
    repeat (wait_pre) tick();
    istb_i = 1'b1;
    irq_i  = irq_i & ~clr_at_istb;
    tick();
    chk("iack_after_istb", {31'd0, iack_o}, 32'd1);
    chk("ivec", {16'd0, ivec_o}, {16'd0, exp_vec_q.pop_front()});
    repeat (hold) begin
      tick();
      chk("iack_hold", {31'd0, iack_o}, 32'd1);
      chk("virq_hold", {31'd0, virq_o}, 32'd1);
    end
    istb_i = 1'b0;
    ack_window = 1'b1;
    tick();
    ack_window = 1'b0;
    chk("irq_ack", {24'd0, irq_ack_o}, {24'd0, exp_ack_q.pop_front()});
    chk("iack_drop", {31'd0, iack_o}, 32'd0);
    chk("virq_drop", {31'd0, virq_o}, 32'd0);
    chk("ivec_clear", {16'd0, ivec_o}, 32'd0);
  endtask

  initial begin
    logic [15:0] vtab [NREQ];
    logic [15:0] seq_vec [4];
    logic [NREQ-1:0] seq_ack [4];
    vtab = '{16'o60, 16'o64, 16'o100, 16'o110, 16'o114, 16'o120, 16'o124, 16'o300};
    for (int k = 0; k < NREQ; k++) vec_i[16*k +: 16] = vtab[k];
    rst_n = 1'b0;
    irq_i = '0;
    istb_i = 1'b0;
    #1;

    // 1: single request on ch1
    do_reset();
    irq_i = 8'b0000_0010;
    chk("t1_virq_before", {31'd0, virq_o}, 32'd0);
    tick();
    chk("t1_virq_latency", {31'd0, virq_o}, 32'd1);
    service(16'o64, 8'b0000_0010, 4, 3, '0);
    tick();
    chk("t1_idle_virq", {31'd0, virq_o}, 32'd0);

    // 2: ch0 preempts ch2 before istb; ch2 served afterwards with 3-cycle turnaround
    do_reset();
    irq_i = 8'b0000_0100;
    tick();
    irq_i = 8'b0000_0101;
    service(16'o60, 8'b0000_0001, 2, 1, '0);
    tick();
    chk("t2_turnaround_dead", {31'd0, virq_o}, 32'd0);
    tick();
    chk("t2_turnaround_virq", {31'd0, virq_o}, 32'd1);
    service(16'o100, 8'b0000_0100, 1, 1, '0);

    // 3: request withdrawn before istb
    do_reset();
    irq_i = 8'b0000_0010;
    tick();
    chk("t3_virq_up", {31'd0, virq_o}, 32'd1);
    tick();
    irq_i = '0;
    tick();
    chk("t3_virq_fall", {31'd0, virq_o}, 32'd0);
    repeat (3) begin
      tick();
      chk("t3_no_iack", {31'd0, iack_o}, 32'd0);
    end

    // 4: withdrawal in the same cycle istb rises -> stray vector, no channel ack
    do_reset();
    irq_i = 8'b0000_0010;
    service(16'o0, 8'b0000_0000, 1, 2, 8'b0000_0010);

    // 5: reset during ACK aborts asynchronously; held request restarts from IDLE
    do_reset();
    irq_i = 8'b0000_0010;
    tick();
    istb_i = 1'b1;
    tick();
    chk("t5_in_ack", {31'd0, iack_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_virq", {31'd0, virq_o}, 32'd0);
    chk("t5_async_iack", {31'd0, iack_o}, 32'd0);
    chk("t5_async_ivec", {16'd0, ivec_o}, 32'd0);
    chk("t5_async_irq_ack", {24'd0, irq_ack_o}, 32'd0);
    istb_i = 1'b0;
    tick();
    chk("t5_held_virq", {31'd0, virq_o}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t5_restart_virq", {31'd0, virq_o}, 32'd1);
    service(16'o64, 8'b0000_0010, 1, 1, '0);

    // 6: ch0 and ch7 both held and re-raised after each ack
    do_reset();
`ifdef INTR_RR_EN
    seq_vec = '{16'o60, 16'o300, 16'o60, 16'o300};
    seq_ack = '{8'h01, 8'h80, 8'h01, 8'h80};
`else
    seq_vec = '{16'o60, 16'o60, 16'o60, 16'o60};
    seq_ack = '{8'h01, 8'h01, 8'h01, 8'h01};
`endif
    rearm_en = 1'b1;
    irq_i = 8'b1000_0001;
    for (int s = 0; s < 4; s++) service(seq_vec[s], seq_ack[s], 3, 1, '0);
    rearm_en = 1'b0;
    rearm_pend = '0;
    irq_i = '0;
    repeat (3) tick();
    chk("t6_quiet_virq", {31'd0, virq_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
